// File: rtl/mod_mul_pow2_stream.sv
// Streaming ML-KEM scaler: coeff_o = coeff_i * 2^k_i mod 3329, one conditional-subtract doubling per clock.
// Optional MOD_MUL_POW2_UNROLL2_EN: two chained doublings per clock in SHIFT.
module mod_mul_pow2_stream #(
  parameter int K_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [11:0]    coeff_i,
  input  logic [K_W-1:0] k_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [11:0]    coeff_o
);

  typedef logic [11:0] coeff_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [12:0] Q = 13'd3329;

  state_t         state_q, state_d;
  coeff_t         acc_q, acc_d;
  logic [K_W-1:0] cnt_q, cnt_d;
  logic           in_ready_s;

  // Raw operands span 0..4095; one subtract suffices since 4095-Q < Q.
  function automatic coeff_t reduce_once(input coeff_t a);
    logic [12:0] x;
    x = {1'b0, a};
    if (x >= Q) begin
      x = x - Q;
    end else begin
      x = x;
    end
    return x[11:0];
  endfunction

  // acc stays in 0..Q-1, so 2*acc < 2Q and a single subtract keeps it there.
  function automatic coeff_t dbl_mod(input coeff_t a);
    logic [12:0] d;
    d = {a, 1'b0};
    if (d >= Q) begin
      d = d - Q;
    end else begin
      d = d;
    end
    return d[11:0];
  endfunction

  assign in_ready_s = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign in_ready   = in_ready_s;
  assign out_valid  = (state_q == DONE);
  assign coeff_o    = acc_q;

  // Next-state, accumulator and doubling-counter logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = reduce_once(coeff_i);
          cnt_d   = k_i;
          state_d = (k_i != '0) ? SHIFT : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
`ifdef MOD_MUL_POW2_UNROLL2_EN
        if (cnt_q >= K_W'(2)) begin
          acc_d   = dbl_mod(dbl_mod(acc_q));
          cnt_d   = cnt_q - K_W'(2);
          state_d = (cnt_q == K_W'(2)) ? DONE : SHIFT;
        end else begin
          acc_d   = dbl_mod(acc_q);
          cnt_d   = '0;
          state_d = DONE;
        end
`else
        acc_d   = dbl_mod(acc_q);
        cnt_d   = cnt_q - K_W'(1);
        if (cnt_q == K_W'(1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
`endif
      end
      DONE: begin
        if (out_ready && in_valid) begin
          acc_d   = reduce_once(coeff_i);
          cnt_d   = k_i;
          state_d = (k_i != '0) ? SHIFT : DONE;
        end else if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 12'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
